bin2bcd_serial: RTL and testbench

//  Sequential binary-to-BCD encoder (shift-add-3 / double-dabble), one bit per clock.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_add3.sv | 17 +
 rtl/bin2bcd_serial.sv | 132 +++++++++++++
 tb/tb_bin2bcd_serial.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial binary-to-BCD encoder.
// Digit limits and the add-3 threshold are used by the datapath and its checks.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [BCD_W-1:0] BCD_MAX     = 4'd9;
  localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble correction: digits of 5 or more get +3 before the shift.
// Valid inputs are 0..9, so the 4-bit sum never wraps.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  output logic [BCD_W-1:0] o_digit_c
);

  always_comb begin
    o_digit_c = i_digit;
    if (i_digit >= ADD3_THRESH) begin
      o_digit_c = i_digit + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_serial.sv
// Sequential shift-add-3 binary-to-BCD encoder, one input bit per clock.
// Start/Busy/Done handshake; BCD and Overflow are held between conversions.
module bin2bcd_serial
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    Start,
  input  logic [WIDTH-1:0]        Bin,
  output logic                    Busy,
  output logic                    Done,
  output logic [BCD_W*DIGITS-1:0] BCD,
  output logic                    Overflow
);

  localparam int unsigned BCD_TOT_W = BCD_W * DIGITS;
  localparam int unsigned CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t r_state;
  state_t w_next_state;
  logic   w_load;
  logic   w_shift;

  logic [WIDTH-1:0]     r_bin_sr;
  logic [BCD_TOT_W-1:0] r_bcd_sr;
  logic                 r_ovf;
  logic [CNT_W-1:0]     r_cnt;

  logic                 r_busy;
  logic                 r_done;
  logic [BCD_TOT_W-1:0] r_bcd;
  logic                 r_overflow;

  logic [BCD_TOT_W-1:0] w_bcd_adj;
  logic [BCD_TOT_W-1:0] w_bcd_next;
  logic                 w_ovf_bit;

  // Per-digit add-3 correction ahead of each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit   (r_bcd_sr[g*BCD_W +: BCD_W]),
      .o_digit_c (w_bcd_adj[g*BCD_W +: BCD_W])
    );
  end

  // The bit falling off the top digit means the value no longer fits in DIGITS.
  assign {w_ovf_bit, w_bcd_next} = {w_bcd_adj, r_bin_sr[WIDTH-1]};

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_load       = 1'b1;
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == '0) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (Start) begin
          w_load       = 1'b1;
          w_next_state = SHIFT;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_bin_sr <= '0;
      r_bcd_sr <= '0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
    end else if (w_load) begin
      r_bin_sr <= Bin;
      r_bcd_sr <= '0;
      r_ovf    <= 1'b0;
      r_cnt    <= CNT_W'(WIDTH - 1);
    end else if (w_shift) begin
      r_bin_sr <= r_bin_sr << 1;
      r_bcd_sr <= w_bcd_next;
      r_ovf    <= r_ovf | w_ovf_bit;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Results are published only when leaving DONE, so partial shifts never show.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_busy <= (w_next_state == SHIFT);
      r_done <= (r_state == DONE);
      if (r_state == DONE) begin
        r_bcd      <= r_bcd_sr;
        r_overflow <= r_ovf;
      end
    end
  end

  assign Busy     = r_busy;
  assign Done     = r_done;
  assign BCD      = r_bcd;
  assign Overflow = r_overflow;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Directed bench for bin2bcd_serial: a 3-digit instance and a 2-digit instance
// for the overflow and held-Start cases.
module tb_bin2bcd_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic        ovf;

  logic        start2;
  logic [7:0]  bin2;
  logic        busy2;
  logic        done2;
  logic [7:0]  bcd2;
  logic        ovf2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bin2bcd_serial #(.WIDTH(8), .DIGITS(3)) u_dut (
    .Clock    (clk),
    .Resetn   (rst_n),
    .Start    (start),
    .Bin      (bin),
    .Busy     (busy),
    .Done     (done),
    .BCD      (bcd),
    .Overflow (ovf)
  );

  bin2bcd_serial #(.WIDTH(8), .DIGITS(2)) u_dut2 (
    .Clock    (clk),
    .Resetn   (rst_n),
    .Start    (start2),
    .Bin      (bin2),
    .Busy     (busy2),
    .Done     (done2),
    .BCD      (bcd2),
    .Overflow (ovf2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bin = '0; start2 = 1'b0; bin2 = '0;
    #12;
    n_total++;
    if ({busy, done, ovf, bcd} !== 15'h0000) $display("FAIL reset_main: got %h expected 0000", {busy, done, ovf, bcd});
    else n_pass++;
    n_total++;
    if ({busy2, done2, ovf2, bcd2} !== 11'h000) $display("FAIL reset_dut2: got %h expected 000", {busy2, done2, ovf2, bcd2});
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero();
    int k = 0;
    bin = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    while (done !== 1'b1 && k < 40) begin tick(); k++; end
    n_total++;
    if (k != 9) $display("FAIL zero_latency: got %0d expected 9", k);
    else n_pass++;
    n_total++;
    if ({ovf, bcd} !== 13'h0000) $display("FAIL zero_value: got %h expected 0000", {ovf, bcd});
    else n_pass++;
  endtask

  task automatic test_max();
    int k = 0;
    int busy_cnt = 0;
    bin = 8'd255; start = 1'b1;
    tick();
    start = 1'b0;
    if (busy === 1'b1) busy_cnt++;
    while (done !== 1'b1 && k < 40) begin
      tick(); k++;
      if (busy === 1'b1) busy_cnt++;
    end
    n_total++;
    if (k != 9) $display("FAIL max_latency: got %0d expected 9", k);
    else n_pass++;
    n_total++;
    if (busy_cnt != 8) $display("FAIL max_busy_cycles: got %0d expected 8", busy_cnt);
    else n_pass++;
    n_total++;
    if ({ovf, bcd} !== {1'b0, 12'h255}) $display("FAIL max_value: got %h expected 0255", {ovf, bcd});
    else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b0) $display("FAIL max_done_width: got %b expected 0", done);
    else n_pass++;
    n_total++;
    if (bcd !== 12'h255) $display("FAIL max_hold: got %h expected 255", bcd);
    else n_pass++;
  endtask

  task automatic test_exhaustive();
    int bad_digits = 0;
    for (int v = 0; v < 256; v++) begin
      int k = 0;
      logic [11:0] exp_bcd;
      exp_bcd = 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
      bin = 8'(v); start = 1'b1;
      tick();
      start = 1'b0;
      while (done !== 1'b1 && k < 40) begin tick(); k++; end
      n_total++;
      if (k != 9 || {ovf, bcd} !== {1'b0, exp_bcd})
        $display("FAIL exhaustive_%0d: got %h after %0d cycles expected %h after 9", v, {ovf, bcd}, k, {1'b0, exp_bcd});
      else n_pass++;
      for (int d = 0; d < 3; d++) begin
        logic [3:0] dig;
        dig = bcd[d*4 +: 4];
        if (dig > 4'd9) bad_digits++;
      end
    end
    n_total++;
    if (bad_digits != 0) $display("FAIL digit_range: got %0d digits above 9 expected 0", bad_digits);
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int k = 0;
    int n_done = 0;
    logic [11:0] seen = 12'hfff;
    bin = 8'd99; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    bin = 8'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) begin
        n_done++;
        seen = bcd;
        if (n_done == 1) k = i + 4;
      end
    end
    n_total++;
    if (n_done != 1) $display("FAIL busy_start_done_count: got %0d expected 1", n_done);
    else n_pass++;
    n_total++;
    if (seen !== 12'h099) $display("FAIL busy_start_value: got %h expected 099", seen);
    else n_pass++;
    n_total++;
    if (k != 9) $display("FAIL busy_start_latency: got %0d expected 9", k);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int k = 0;
    int n_done = 0;
    bin = 8'd200; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, ovf, bcd} !== 15'h0000) $display("FAIL abort_outputs: got %h expected 0000", {busy, done, ovf, bcd});
    else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    n_total++;
    if (n_done != 0) $display("FAIL abort_no_done: got %0d active cycles expected 0", n_done);
    else n_pass++;
    bin = 8'd42; start = 1'b1;
    tick();
    start = 1'b0;
    while (done !== 1'b1 && k < 40) begin tick(); k++; end
    n_total++;
    if (k != 9 || {ovf, bcd} !== {1'b0, 12'h042})
      $display("FAIL abort_restart: got %h after %0d cycles expected 0042 after 9", {ovf, bcd}, k);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int k = 0;
    bin = 8'd123; start = 1'b1;
    tick();
    bin = 8'd64;
    while (done !== 1'b1 && k < 40) begin tick(); k++; end
    n_total++;
    if (k != 9 || {ovf, bcd} !== {1'b0, 12'h123})
      $display("FAIL b2b_first: got %h after %0d cycles expected 0123 after 9", {ovf, bcd}, k);
    else n_pass++;
    n_total++;
    if (busy !== 1'b1) $display("FAIL b2b_restart_busy: got %b expected 1", busy);
    else n_pass++;
    start = 1'b0;
    k = 0;
    tick();
    k++;
    while (done !== 1'b1 && k < 40) begin tick(); k++; end
    n_total++;
    if (k != 9 || {ovf, bcd} !== {1'b0, 12'h064})
      $display("FAIL b2b_second: got %h after %0d cycles expected 0064 after 9", {ovf, bcd}, k);
    else n_pass++;
  endtask

  task automatic test_overflow_held_start();
    int k = 0;
    bin2 = 8'd200; start2 = 1'b1;
    tick();
    bin2 = 8'd45;
    while (done2 !== 1'b1 && k < 40) begin tick(); k++; end
    n_total++;
    if (k != 9 || {ovf2, bcd2} !== {1'b1, 8'h00})
      $display("FAIL ovf_value: got %h after %0d cycles expected 100 after 9", {ovf2, bcd2}, k);
    else n_pass++;
    n_total++;
    if (busy2 !== 1'b1) $display("FAIL ovf_held_start_busy: got %b expected 1", busy2);
    else n_pass++;
    start2 = 1'b0;
    k = 0;
    tick();
    k++;
    while (done2 !== 1'b1 && k < 40) begin tick(); k++; end
    n_total++;
    if (k != 9 || {ovf2, bcd2} !== {1'b0, 8'h45})
      $display("FAIL ovf_second: got %h after %0d cycles expected 045 after 9", {ovf2, bcd2}, k);
    else n_pass++;
    bin2 = 8'd99; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    k = 0;
    while (done2 !== 1'b1 && k < 40) begin tick(); k++; end
    n_total++;
    if ({ovf2, bcd2} !== {1'b0, 8'h99}) $display("FAIL ovf_boundary_99: got %h expected 099", {ovf2, bcd2});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_exhaustive();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    test_overflow_held_start();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
